radix_serializer: RTL and testbench
===================================

# radix_serializer

Parametrised, registered successor to the sized-number pass-through block. It captures a WIDTH-bit value plus a radix mode and emits it as ASCII digits, one character per cycle, MSB first. Binary mode matches `%b` output and hex mode matches lowercase `%h`. It sits between datapath probes and the debug UART/console byte stream, with valid/ready handshakes on both sides.

## Interface
- `WIDTH`, default 16: bit width of the captured value; legal range 1..64.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `in_valid` input, 1 bit: the upstream value/mode pair is valid.
- `in_ready` output, 1 bit: the block can accept a value; high only in IDLE.
- `in_value` input, WIDTH bits: number to format.
- `in_mode` input, 1 bit: 0 = binary, 1 = hex.
- `out_valid` output, 1 bit: `out_char` holds a valid character.
- `out_ready` input, 1 bit: the downstream consumer accepts `out_char`.
- `out_char` output, 8 bits: ASCII digit.
- `out_last` output, 1 bit: marks the final character of the current number.

## Operation
- States:
  - IDLE: `in_ready`=1, `out_valid`=0.
  - EMIT: `in_ready`=0, `out_valid`=1.
- IDLE→EMIT on `in_valid && in_ready`.
  - On that edge, latch `in_value` into the shift register and `in_mode` into the mode register.
  - Load the digit counter with NCHAR-1.
- Character count:
  - Binary: NCHAR_B = WIDTH.
  - Hex: NCHAR_H = ceil(WIDTH/4).
  - The counter is $clog2(WIDTH+1) bits wide.
- Hex zero-extends the value to 4·NCHAR_H bits, so the top nibble is zero-padded when WIDTH%4≠0.
- Digit mapping:
  - Binary: '0'=0x30, '1'=0x31.
  - Hex: 0–9 map to 0x30–0x39; a–f map to 0x61–0x66 (lowercase only).
- The current digit is the most significant remaining digit.
- On each `out_valid && out_ready` edge:
  - Shift left by 1 (binary) or 4 (hex).
  - Decrement the counter.
- `out_last` = (counter == 0) while in EMIT; it is 0 in IDLE.
- EMIT→IDLE on the edge where the last character is accepted.
- Stall: while `out_valid && !out_ready`, hold `out_char`, `out_last`, the counter and the shift register stable.
- `in_value`/`in_mode` changes during EMIT are ignored; only the latched copies are used.
- `rst` is dominant over any handshake in the same cycle. Reset mid-operation discards the partial number and emits no further characters from it.
- Reset values: `in_ready`=1, `out_valid`=0, `out_char`=8'h00, `out_last`=0; state IDLE; counter and shift register 0.
- `out_char` is registered or decoded from registered state only; there is no combinational path from `in_*` or `out_ready` to `out_char`/`out_valid`.

## Timing
- Value accepted at edge k → first character valid in the cycle after edge k.
- With `out_ready` held high:
  - A number takes NCHAR cycles of `out_valid`.
  - `in_ready` returns high in the cycle after the last acceptance.
  - Throughput is NCHAR+1 cycles per number.
- No back-to-back bypass: `in_ready` is 0 during the entire cycle in which the last character is accepted.
- `out_ready` may toggle arbitrarily; every character is transferred exactly once, in order.

## Structure
- Package `radix_pkg`:
  - Mode constants `MODE_BIN`=1'b0, `MODE_HEX`=1'b1.
  - ASCII constants `ASCII_0`=8'h30, `ASCII_A_LC`=8'h61.
  - State encoding IDLE/EMIT.
- Sub-module `nibble_to_ascii`: combinational, 4-bit in → 8-bit lowercase ASCII out. Used for the hex path; binary uses the same module with the upper 3 bits zero.
- Top level contains the FSM, shift register, counter and output registers.

## Test plan
- WIDTH=16, hex, `in_value`=16'hea75, `out_ready`=1 → `out_char` 0x65,0x61,0x37,0x35 on 4 consecutive cycles, `out_last` only on 0x35, `in_ready` high the following cycle.
- WIDTH=6, binary, 6'b101001 → "101001" (0x31,0x30,0x31,0x30,0x30,0x31); then 6'b011010 → "011010"; last flag on the 6th character of each.
- WIDTH=6, hex, 6'b101001 → "29" (0x32,0x39), confirming zero-padded top nibble; 6'h3f → "3f".
- WIDTH=16, hex 16'hfb17, `out_ready` pattern 1,0,0,1,0,1,1 → exactly "fb17" in order; `out_char`/`out_last` stable across the stall cycles; no duplicate or dropped characters.
- Assert `rst` during the 2nd character of 16'hea75 → next cycle `out_valid`=0, `out_char`=0x00, `in_ready`=1. A subsequent 16'h0001 in hex emits "0001" with no leftover digits.
- Hold `in_valid`=1 and change `in_value` during EMIT → output matches only the value latched at acceptance; a second value is accepted only once `in_ready` is high.

Source files
------------

// File: rtl/radix_pkg.sv
// Shared constants and state encoding for the radix serializer.
package radix_pkg;

  localparam logic MODE_BIN = 1'b0;
  localparam logic MODE_HEX = 1'b1;

  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_A_LC = 8'h61;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational 4-bit digit to lowercase ASCII character.
module nibble_to_ascii
  import radix_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  // Digits below ten map onto '0'..'9', the rest onto 'a'..'f'.
  always_comb begin
    ascii = 8'h00;
    if (nibble < 4'd10) begin
      ascii = ASCII_0 + {4'h0, nibble};
    end else begin
      ascii = ASCII_A_LC + {4'h0, nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/radix_serializer.sv
// Captures a WIDTH-bit value and streams it as ASCII binary or lowercase hex
// digits, MSB first, with valid/ready handshakes on both sides.
module radix_serializer
  import radix_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_value,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_char,
  output logic             out_last
);

  localparam int NCHAR_H = (WIDTH + 3) / 4;
  localparam int SW      = 4 * NCHAR_H;
  localparam int CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_B = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_H = CW'(NCHAR_H - 1);

  state_t        state_r;
  logic [SW-1:0] sr_r;
  logic [CW-1:0] cnt_r;
  logic          mode_r;

  logic [SW-1:0] sr_next_s;
  logic          mode_next_s;
  logic [3:0]    digit_s;
  logic [7:0]    char_next_s;

  // Next shift-register contents and the digit that will be on out_char after it.
  always_comb begin
    sr_next_s   = sr_r;
    mode_next_s = mode_r;
    if (state_r == IDLE) begin
      sr_next_s   = SW'(in_value);
      mode_next_s = in_mode;
    end else if (mode_r == MODE_HEX) begin
      sr_next_s = sr_r << 4;
    end else begin
      sr_next_s = sr_r << 1;
    end
    if (mode_next_s == MODE_HEX) begin
      digit_s = sr_next_s[SW-1 -: 4];
    end else begin
      digit_s = {3'b000, sr_next_s[WIDTH-1]};
    end
  end

  nibble_to_ascii u_n2a (
    .nibble (digit_s),
    .ascii  (char_next_s)
  );

  // Handshake FSM; every output is registered so nothing combinational reaches out_*.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      sr_r      <= '0;
      cnt_r     <= '0;
      mode_r    <= MODE_BIN;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_char  <= 8'h00;
      out_last  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            state_r   <= EMIT;
            sr_r      <= sr_next_s;
            mode_r    <= mode_next_s;
            cnt_r     <= (mode_next_s == MODE_HEX) ? LAST_H : LAST_B;
            out_char  <= char_next_s;
            out_last  <= (mode_next_s == MODE_HEX) ? (LAST_H == '0) : (LAST_B == '0);
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (cnt_r == '0) begin
              state_r   <= IDLE;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_char  <= 8'h00;
            end else begin
              sr_r     <= sr_next_s;
              cnt_r    <= cnt_r - CW'(1);
              out_char <= char_next_s;
              out_last <= (cnt_r == CW'(1));
            end
          end else begin
            state_r <= EMIT;
          end
        end
        default: begin
          state_r   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          out_char  <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_radix_serializer.sv
// Directed bench driving a WIDTH=16 and a WIDTH=6 serializer with hand-computed digit strings.
module tb_radix_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_value = 16'h0000;
  logic        in_mode = 1'b0;
  logic        out_ready = 1'b1;
  logic        sel = 1'b0;

  logic       in_ready16, out_valid16, out_last16;
  logic [7:0] out_char16;
  logic       in_ready6, out_valid6, out_last6;
  logic [7:0] out_char6;

  logic       obs_in_ready, obs_out_valid, obs_out_last;
  logic [7:0] obs_out_char;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  radix_serializer #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid && !sel), .in_ready(in_ready16),
    .in_value(in_value), .in_mode(in_mode),
    .out_valid(out_valid16), .out_ready(out_ready),
    .out_char(out_char16), .out_last(out_last16)
  );

  radix_serializer #(.WIDTH(6)) u6 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid && sel), .in_ready(in_ready6),
    .in_value(in_value[5:0]), .in_mode(in_mode),
    .out_valid(out_valid6), .out_ready(out_ready),
    .out_char(out_char6), .out_last(out_last6)
  );

  assign obs_in_ready  = sel ? in_ready6  : in_ready16;
  assign obs_out_valid = sel ? out_valid6 : out_valid16;
  assign obs_out_last  = sel ? out_last6  : out_last16;
  assign obs_out_char  = sel ? out_char6  : out_char16;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one value for a single accepting edge, waiting (bounded) for in_ready.
  task automatic send(input logic [15:0] v, input logic m);
    int n = 0;
    while (!obs_in_ready && n < 40) begin
      tick();
      n++;
    end
    check_eq("send_in_ready", 64'(obs_in_ready), 64'd1);
    in_value = v;
    in_mode  = m;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Consume the expected string; pat gives out_ready per cycle, then 1 thereafter.
  task automatic recv(input string s, input logic [15:0] pat, input int npat);
    int p = 0;
    int i = 0;
    while (i < s.len()) begin
      check_eq("out_valid", 64'(obs_out_valid), 64'd1);
      check_eq("in_ready_busy", 64'(obs_in_ready), 64'd0);
      check_eq({"char_", s}, 64'(obs_out_char), 64'(s[i]));
      check_eq({"last_", s}, 64'(obs_out_last), 64'(i == s.len() - 1));
      out_ready = (p < npat) ? pat[p] : 1'b1;
      p++;
      if (out_ready) i++;
      tick();
    end
    out_ready = 1'b1;
    check_eq({"done_valid_", s}, 64'(obs_out_valid), 64'd0);
    check_eq({"done_ready_", s}, 64'(obs_in_ready), 64'd1);
    check_eq({"done_last_", s}, 64'(obs_out_last), 64'd0);
  endtask

  initial begin
    tick();
    tick();
    tick();
    check_eq("rst_in_ready16", 64'(in_ready16), 64'd1);
    check_eq("rst_valid16", 64'(out_valid16), 64'd0);
    check_eq("rst_char16", 64'(out_char16), 64'h00);
    check_eq("rst_last16", 64'(out_last16), 64'd0);
    check_eq("rst_in_ready6", 64'(in_ready6), 64'd1);
    check_eq("rst_valid6", 64'(out_valid6), 64'd0);
    rst = 1'b0;
    tick();

    sel = 1'b0;
    send(16'hea75, 1'b1);
    recv("ea75", 16'h0000, 0);

    sel = 1'b1;
    send(16'h0029, 1'b0);
    recv("101001", 16'h0000, 0);
    send(16'h001a, 1'b0);
    recv("011010", 16'h0000, 0);
    send(16'h0029, 1'b1);
    recv("29", 16'h0000, 0);
    send(16'h003f, 1'b1);
    recv("3f", 16'h0000, 0);

    // Ready pattern 1,0,0,1,0,1,1 (bit 0 is the first cycle).
    sel = 1'b0;
    send(16'hfb17, 1'b1);
    recv("fb17", 16'b1101001, 7);

    // Reset while the second character is on the bus.
    send(16'hea75, 1'b1);
    check_eq("pre_rst_char0", 64'(obs_out_char), 64'h65);
    tick();
    check_eq("pre_rst_char1", 64'(obs_out_char), 64'h61);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_rst_valid", 64'(obs_out_valid), 64'd0);
    check_eq("mid_rst_char", 64'(obs_out_char), 64'h00);
    check_eq("mid_rst_in_ready", 64'(obs_in_ready), 64'd1);
    send(16'h0001, 1'b1);
    recv("0001", 16'h0000, 0);

    // in_valid held high while in_value changes during EMIT.
    in_value = 16'h1234;
    in_mode  = 1'b1;
    in_valid = 1'b1;
    tick();
    in_value = 16'hffff;
    recv("1234", 16'h0000, 0);
    tick();
    in_valid = 1'b0;
    recv("ffff", 16'h0000, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
